// File: rtl/eco_sweep_driver_pkg.sv
// Shared constants for the ECO sweep driver: FSM state encoding and default sizes.
package eco_pkg;

    // FSM state encoding; the ST_ prefix keeps these clear of the SETTLE parameter name
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_CHECK  = 2'd2,
        ST_DONE   = 2'd3
    } eco_state_e;

    localparam int DEF_WIDTH  = 3;
    localparam int DEF_SETTLE = 2;
    localparam int DEF_ERRW   = 7;

endpackage

// File: rtl/eco_sweep_if.sv
// Bundle between the sweep driver and the slice/bench around it.
// Handshake: start is a request level sampled on the rising edge; it is accepted
// only while the driver is not busy (IDLE or DONE) and is otherwise dropped, with
// no queuing. busy acknowledges acceptance from the following cycle; done marks
// results valid until the next accepted start or reset.
interface eco_sweep_if #(
    parameter int WIDTH = 3,
    parameter int ERRW  = 7
);
    logic                 start;
    logic [WIDTH-1:0]     a_out;
    logic [WIDTH-1:0]     b_out;
    logic [WIDTH-1:0]     y_in;
    logic                 busy;
    logic                 done;
    logic                 pass;
    logic [ERRW-1:0]      err_count;
    logic [2*WIDTH-1:0]   first_fail_vec;
    logic                 first_fail_valid;
    logic [1:0]           dbg_state;

    // Driver side
    modport master (
        input  start, y_in,
        output a_out, b_out, busy, done, pass, err_count,
               first_fail_vec, first_fail_valid, dbg_state
    );

    // Slice / controller side
    modport slave (
        output start, y_in,
        input  a_out, b_out, busy, done, pass, err_count,
               first_fail_vec, first_fail_valid, dbg_state
    );
endinterface

// File: rtl/eco_golden_ref.sv
// Golden function of the slice under test; swap this module per ECO case.
module eco_golden_ref #(
    parameter int WIDTH = 3
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] exp
);
    // Bitwise NOR reference
    always_comb begin
        exp = ~(a | b);
    end
endmodule

// File: rtl/eco_sweep_driver.sv
// Sweeps every {b, a} operand pair into the slice, waits SETTLE cycles, checks y
// against the golden model, and reports error count, first failing vector and pass.
module eco_sweep_driver
    import eco_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int SETTLE = DEF_SETTLE,
    parameter int ERRW   = DEF_ERRW
) (
    input  logic         clk,
    input  logic         rst,
    eco_sweep_if.master  bus
);
    localparam int VW = 2 * WIDTH;
    // Settle counter only needs to reach SETTLE-1; keep at least one bit
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((SETTLE > 0) ? SETTLE - 1 : 0);
    // With SETTLE=0 the settle phase is skipped entirely
    localparam eco_state_e VEC_ENTRY = (SETTLE == 0) ? ST_CHECK : ST_SETTLE;

    eco_state_e        state_q, state_d;
    logic [VW-1:0]     vec_q, vec_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [ERRW-1:0]   err_q, err_d;
    logic [VW-1:0]     ffvec_q, ffvec_d;
    logic              ffvalid_q, ffvalid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [WIDTH-1:0]  a_cur, b_cur, exp_y;
    logic              mismatch;
    logic              vec_last;

    // FSM control strobes
    logic              accept;
    logic              cnt_inc;
    logic              check_en;

    assign a_cur    = vec_q[WIDTH-1:0];
    assign b_cur    = vec_q[VW-1:WIDTH];
    assign vec_last = (vec_q == {VW{1'b1}});

    eco_golden_ref #(.WIDTH(WIDTH)) u_golden (
        .a   (a_cur),
        .b   (b_cur),
        .exp (exp_y)
    );

    assign mismatch = |(bus.y_in ^ exp_y);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    state_d = VEC_ENTRY;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                state_d = vec_last ? ST_DONE : VEC_ENTRY;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM output decode: control strobes for the datapath
    always_comb begin
        accept   = 1'b0;
        cnt_inc  = 1'b0;
        check_en = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: accept   = bus.start;
            ST_SETTLE:        cnt_inc  = 1'b1;
            ST_CHECK:         check_en = 1'b1;
            default: ;
        endcase
    end

    // Datapath next-state: vector, settle counter, error tracking, status flags
    always_comb begin
        vec_d     = vec_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        ffvec_d   = ffvec_q;
        ffvalid_d = ffvalid_q;
        busy_d    = busy_q;
        done_d    = done_q;
        if (accept) begin
            vec_d     = '0;
            cnt_d     = '0;
            err_d     = '0;
            ffvec_d   = '0;
            ffvalid_d = 1'b0;
            done_d    = 1'b0;
            busy_d    = 1'b1;
        end
        if (cnt_inc) begin
            cnt_d = cnt_q + 1'b1;
        end
        if (check_en) begin
            if (mismatch) begin
                if (err_q != {ERRW{1'b1}}) begin
                    err_d = err_q + 1'b1;
                end
                if (!ffvalid_q) begin
                    ffvec_d   = {b_cur, a_cur};
                    ffvalid_d = 1'b1;
                end
            end
            if (vec_last) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end else begin
                vec_d = vec_q + 1'b1;
                cnt_d = '0;
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            vec_q     <= '0;
            cnt_q     <= '0;
            err_q     <= '0;
            ffvec_q   <= '0;
            ffvalid_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            vec_q     <= vec_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            ffvec_q   <= ffvec_d;
            ffvalid_q <= ffvalid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.a_out            = a_cur;
    assign bus.b_out            = b_cur;
    assign bus.busy             = busy_q;
    assign bus.done             = done_q;
    assign bus.pass             = done_q & (err_q == '0);
    assign bus.err_count        = err_q;
    assign bus.first_fail_vec   = ffvec_q;
    assign bus.first_fail_valid = ffvalid_q;
    assign bus.dbg_state        = state_q;

endmodule

// File: tb/tb_eco_sweep_driver.sv
// Directed bench: three driver instances (defaults, SETTLE=0, ERRW=3) each
// driving a bench-side slice model with a selectable fault.
module tb_eco_sweep_driver;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    logic start_v [3];
    int   mode0 = 0;

    logic             done_w [3];
    logic             busy_w [3];
    logic [5:0]       ab_w   [3];

    eco_sweep_if #(.WIDTH(3), .ERRW(7)) if0 ();
    eco_sweep_if #(.WIDTH(3), .ERRW(7)) if1 ();
    eco_sweep_if #(.WIDTH(3), .ERRW(3)) if2 ();

    eco_sweep_driver #(.WIDTH(3), .SETTLE(2), .ERRW(7)) u0 (.clk(clk), .rst(rst), .bus(if0.master));
    eco_sweep_driver #(.WIDTH(3), .SETTLE(0), .ERRW(7)) u1 (.clk(clk), .rst(rst), .bus(if1.master));
    eco_sweep_driver #(.WIDTH(3), .SETTLE(2), .ERRW(3)) u2 (.clk(clk), .rst(rst), .bus(if2.master));

    // Clock
    always #5 clk = ~clk;

    // Slice model: 0 ideal NOR, 1 y[1] stuck at 0, 2 every bit inverted
    function automatic logic [2:0] slice(input int m, input logic [2:0] a, input logic [2:0] b);
        logic [2:0] ideal;
        ideal = ~(a | b);
        case (m)
            1:       return ideal & 3'b101;
            2:       return ~ideal;
            default: return ideal;
        endcase
    endfunction

    assign if0.y_in  = slice(mode0, if0.a_out, if0.b_out);
    assign if1.y_in  = slice(0,     if1.a_out, if1.b_out);
    assign if2.y_in  = slice(2,     if2.a_out, if2.b_out);
    assign if0.start = start_v[0];
    assign if1.start = start_v[1];
    assign if2.start = start_v[2];

    assign done_w[0] = if0.done;  assign busy_w[0] = if0.busy;  assign ab_w[0] = {if0.b_out, if0.a_out};
    assign done_w[1] = if1.done;  assign busy_w[1] = if1.busy;  assign ab_w[1] = {if1.b_out, if1.a_out};
    assign done_w[2] = if2.done;  assign busy_w[2] = if2.busy;  assign ab_w[2] = {if2.b_out, if2.a_out};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // One-cycle start pulse; returns #1 after the start edge
    task automatic pulse_start(input int idx);
        @(negedge clk);
        start_v[idx] = 1'b1;
        @(posedge clk);
        #1;
        start_v[idx] = 1'b0;
    endtask

    // Counts edges from the start edge to the edge that raises done (bounded).
    // Optionally re-pulses start at edge repulse_at and snapshots {b,a} after edge 15.
    task automatic run_sweep(input int idx, input int repulse_at, output int cyc,
                             output logic [5:0] snap, output bit busy_ok);
        cyc = 0;
        snap = '0;
        busy_ok = 1'b1;
        while (cyc < 1000) begin
            start_v[idx] = (repulse_at > 0 && cyc == repulse_at - 1);
            @(posedge clk);
            #1;
            cyc++;
            if (cyc == 15) snap = ab_w[idx];
            if (done_w[idx]) break;
            if (!busy_w[idx]) busy_ok = 1'b0;
        end
        start_v[idx] = 1'b0;
    endtask

    int         cyc;
    logic [5:0] snap;
    bit         busy_ok;

    initial begin
        foreach (start_v[i]) start_v[i] = 1'b0;

        // Reset
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_state0", if0.dbg_state, 0);
        check("rst_busy0",  if0.busy, 0);
        check("rst_done0",  if0.done, 0);
        check("rst_pass0",  if0.pass, 0);
        check("rst_ab0",    {if0.b_out, if0.a_out}, 0);
        check("rst_err0",   if0.err_count, 0);
        check("rst_ffv0",   if0.first_fail_valid, 0);
        check("rst_ffvec0", if0.first_fail_vec, 0);
        check("rst_done1",  if1.done, 0);
        check("rst_err2",   if2.err_count, 0);

        // Ideal slice, defaults: 64 vectors * 3 cycles
        pulse_start(0);
        check("ideal_busy_at_start", if0.busy, 1);
        run_sweep(0, 0, cyc, snap, busy_ok);
        check("ideal_cycles", cyc, 192);
        check("ideal_busy_held", busy_ok, 1);
        check("ideal_snap15", snap, 6'd5);
        check("ideal_busy_end", if0.busy, 0);
        check("ideal_pass", if0.pass, 1);
        check("ideal_err", if0.err_count, 0);
        check("ideal_ffv", if0.first_fail_valid, 0);
        check("ideal_ab_last", {if0.b_out, if0.a_out}, 6'b111111);
        check("ideal_state", if0.dbg_state, 3);

        // y[1] stuck at 0, with an ignored start re-pulse at edge 40
        mode0 = 1;
        pulse_start(0);
        run_sweep(0, 40, cyc, snap, busy_ok);
        check("stuck_cycles", cyc, 192);
        check("stuck_busy_held", busy_ok, 1);
        check("stuck_err", if0.err_count, 16);
        check("stuck_ffvec", if0.first_fail_vec, 0);
        check("stuck_ffv", if0.first_fail_valid, 1);
        check("stuck_pass", if0.pass, 0);
        check("stuck_done", if0.done, 1);

        // Restart from DONE: status clears at the start edge
        mode0 = 0;
        pulse_start(0);
        check("restart_done", if0.done, 0);
        check("restart_err", if0.err_count, 0);
        check("restart_ffv", if0.first_fail_valid, 0);
        check("restart_busy", if0.busy, 1);
        check("restart_pass", if0.pass, 0);
        run_sweep(0, 0, cyc, snap, busy_ok);
        check("restart_cycles", cyc, 192);
        check("restart_pass_end", if0.pass, 1);

        // Reset mid-sweep with start also high; 8 mismatches precede it
        mode0 = 1;
        pulse_start(0);
        repeat (48) @(posedge clk);
        #1;
        check("mid_err", if0.err_count, 8);
        check("mid_ab", {if0.b_out, if0.a_out}, 6'd16);
        @(negedge clk);
        rst = 1'b1;
        start_v[0] = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        start_v[0] = 1'b0;
        check("midrst_state", if0.dbg_state, 0);
        check("midrst_busy", if0.busy, 0);
        check("midrst_done", if0.done, 0);
        check("midrst_ab", {if0.b_out, if0.a_out}, 0);
        check("midrst_err", if0.err_count, 0);
        check("midrst_ffv", if0.first_fail_valid, 0);
        @(posedge clk);
        #1;
        check("midrst_stays_idle", if0.dbg_state, 0);
        mode0 = 0;

        // SETTLE=0: one cycle per vector
        pulse_start(1);
        check("s0_first_state", if1.dbg_state, 2);
        run_sweep(1, 0, cyc, snap, busy_ok);
        check("s0_cycles", cyc, 64);
        check("s0_snap15", snap, 6'd15);
        check("s0_pass", if1.pass, 1);
        check("s0_ab_last", {if1.b_out, if1.a_out}, 6'b111111);

        // ERRW=3, every vector wrong: counter saturates
        pulse_start(2);
        run_sweep(2, 0, cyc, snap, busy_ok);
        check("sat_cycles", cyc, 192);
        check("sat_err", if2.err_count, 3'b111);
        check("sat_ffvec", if2.first_fail_vec, 0);
        check("sat_ffv", if2.first_fail_valid, 1);
        check("sat_pass", if2.pass, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/eco_sweep_driver.md
Name: eco_sweep_driver

Overview:
- Sequential stimulus/response driver for the team's WIDTH-bit, two-operand gate-level ECO test slices.
- On a start request it sweeps every (a, b) operand combination into the slice, waits a settle time, samples y and compares it against a golden bitwise-NOR model.
- Reports the mismatch count, the first failing vector and a pass flag.
- Sits on the drive side of the combinational slice under test, in bench or BIST wrappers.

Parameters:
- WIDTH, 3: operand/result width of the slice under test.
- SETTLE, 2: wait cycles after a vector is applied, before sampling y_in; 0 allowed.
- ERRW, 7: width of the mismatch counter; the counter saturates.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a sweep; accepted only in IDLE or DONE.
- a_out  output  WIDTH  operand a to the slice.
- b_out  output  WIDTH  operand b to the slice.
- y_in  input  WIDTH  slice result.
- busy  output  1  high while a sweep is in progress.
- done  output  1  high from sweep completion until the next accepted start or reset.
- pass  output  1  equals done AND (err_count == 0).
- err_count  output  ERRW  number of mismatching vectors, saturating at all-ones.
- first_fail_vec  output  2*WIDTH  {b, a} of the first mismatching vector.
- first_fail_valid  output  1  first_fail_vec holds a captured value.

Behaviour:
- Reset (synchronous, rst=1 at a rising edge):
  - state becomes IDLE.
  - a_out, b_out, err_count and first_fail_vec become 0.
  - busy, done, pass and first_fail_valid become 0.
  - Reset overrides start and an in-progress sweep at the same edge.
- Internal vector register vec, 2*WIDTH bits. Registered drive: a_out = vec[WIDTH-1:0], b_out = vec[2*WIDTH-1:WIDTH].
- Golden model, per bit i: exp[i] = ~(a_out[i] | b_out[i]). A mismatch is any bit with y_in != exp.
- FSM states: IDLE, SETTLE, CHECK, DONE.
  - IDLE/DONE, start=1 -> SETTLE. Same edge: vec<=0, settle counter<=0, err_count<=0, first_fail_valid<=0, first_fail_vec<=0, done<=0, busy<=1.
  - SETTLE: counts SETTLE cycles, then goes to CHECK. With SETTLE=0 it spends zero cycles here, i.e. CHECK is entered straight from the start edge.
  - CHECK: samples y_in for the vector currently driven.
    - On mismatch: err_count increments unless already all-ones.
    - If first_fail_valid=0: capture {b_out, a_out} and set first_fail_valid.
    - If vec is all-ones: -> DONE, busy<=0, done<=1.
    - Otherwise vec<=vec+1, settle counter cleared, -> SETTLE (or stay in CHECK if SETTLE=0).
  - DONE: outputs held. a_out/b_out hold the last vector until the next start or reset.
- start while busy is ignored; no queuing.
- Cycle counts:
  - Each vector occupies SETTLE+1 cycles.
  - Full sweep = 2^(2*WIDTH)*(SETTLE+1) cycles from the start edge to the edge that sets done. Default: 64*3 = 192.
- pass is combinationally derived from registered done and err_count; it is 0 whenever done=0.
- err_count and first_fail_vec update live during the sweep and are valid to read at done.
- vec never wraps: the sweep terminates at all-ones.

Decomposition:
- Shared package eco_pkg:
  - state encoding constants IDLE=2'd0, SETTLE=2'd1, CHECK=2'd2, DONE=2'd3.
  - default WIDTH/SETTLE/ERRW constants.
- One sub-module, eco_golden_ref: parameterised WIDTH, purely combinational bitwise NOR, inputs a and b, output exp. Kept separate so the golden function can be swapped per ECO case.
- The FSM, counters and capture logic stay in eco_sweep_driver.

Test Plan:
- Ideal slice model (y = ~(a|b)), defaults, pulse start -> busy for 192 cycles; then done=1, pass=1, err_count=0, first_fail_valid=0, a_out=b_out=3'b111.
- Slice with y[1] stuck at 0 -> err_count=16 (all vectors with a1=b1=0), first_fail_vec=6'b000000, first_fail_valid=1, pass=0.
- start re-pulsed at cycle 40 of a sweep -> ignored; done still arrives at cycle 192. Then start in DONE -> done, err_count and first_fail_valid clear at the start edge and a new sweep runs.
- rst asserted at cycle 50 of a sweep, with start also high -> next cycle: IDLE, busy=0, done=0, a_out=b_out=0, err_count=0.
- SETTLE=0 with the ideal model -> done exactly 64 cycles after start, pass=1.
- ERRW=3, slice output = ~exp on every vector -> err_count saturates at 3'b111; first_fail_vec=0; done at cycle 192.
